// File: rtl/zjh_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package zjh_adder_pkg;

    // Width of one adder slice in bits.
    localparam int NIBBLE = 4;

    // FSM state encoding, kept as plain constants for compatibility with older tools.
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/zjh_nibble_add_seq_if.sv
// Bus bundle for zjh_nibble_add_seq: request side, result side and FSM debug state.
//
// Handshake: a request is accepted on the rising clk edge where start=1 and ready=1;
// a, b and cin are captured on that same edge and never looked at again. There is no
// backpressure on the result: done is a single-cycle pulse, and sum/cout/ovf stay
// valid from that pulse until the next accepted request.
interface zjh_nibble_add_seq_if
    import zjh_adder_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    state_t           state_dbg;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout, ovf, state_dbg
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout, ovf, state_dbg
    );
endinterface

// File: rtl/zjh_74HC283.sv
// 4-bit binary full adder with fast carry, modelled as an explicit ripple of full adders.
module zjh_74HC283 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);
    logic [4:0] c;

    // Ripple the carry through the four bit positions.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c0;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c4 = c[4];
endmodule

// File: rtl/zjh_nibble_add_seq.sv
// Nibble-serial adder: one 4-bit slice, one nibble per RUN cycle, result on a done pulse.
module zjh_nibble_add_seq
    import zjh_adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic                clk,
    input  logic                rst,
    zjh_nibble_add_seq_if.slave bus
);
    localparam int            NIBS   = WIDTH / NIBBLE;
    localparam int            KW     = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBS - 1);

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_s;
    logic             sl_c4;
    logic             msb_cin;

    // Present nibble k of the latched operands to the slice.
    assign sl_a = a_q[k*NIBBLE +: NIBBLE];
    assign sl_b = b_q[k*NIBBLE +: NIBBLE];

    zjh_74HC283 u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .c0 (carry),
        .s  (sl_s),
        .c4 (sl_c4)
    );

    // Carry into the top bit of the current nibble; only used on the final nibble,
    // where that bit is the operand MSB.
    assign msb_cin = sl_s[3] ^ sl_a[3] ^ sl_b[3];

    // Sequencer: accept in IDLE, one nibble per RUN cycle, one DONE cycle, back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            k      <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        carry <= bus.cin;
                        k     <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[k*NIBBLE +: NIBBLE] <= sl_s;
                    carry <= sl_c4;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        cout_q <= sl_c4;
                        ovf_q  <= msb_cin ^ sl_c4;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state == ST_IDLE);
    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = (state == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_zjh_nibble_add_seq.sv
// Bench for zjh_nibble_add_seq: directed literal cases plus a per-cycle reference model.
module tb_zjh_nibble_add_seq;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk;
    logic rst;

    zjh_nibble_add_seq_if #(.WIDTH(W)) bus ();

    zjh_nibble_add_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        longint    ua;
        longint    sa;
        logic [W-1:0] s;
        logic      co;
        logic      ov;
        ua = longint'(x) + longint'(y) + longint'(c);
        s  = ua[W-1:0];
        co = (ua >= (longint'(1) << W));
        sa = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        ov = (sa > ((longint'(1) << (W - 1)) - 1)) || (sa < -(longint'(1) << (W - 1)));
        return {ov, co, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_res;
    logic [W+1:0] e_res;
    bit           pend      = 1'b0;
    bit           rst_seen  = 1'b0;
    bit           have_last = 1'b0;
    bit           idle_now;
    bit           e_busy;
    bit           e_done;
    int           acc_cyc   = 0;
    int           d;

    always @(negedge clk) begin
        idle_now = !pend;
        if (rst_seen) begin
            check("rst_ready", 32'(bus.ready), 1);
            check("rst_busy",  32'(bus.busy),  0);
            check("rst_done",  32'(bus.done),  0);
            check("rst_sum",   32'(bus.sum),   0);
            check("rst_cout",  32'(bus.cout),  0);
            check("rst_ovf",   32'(bus.ovf),   0);
        end else begin
            d      = pend ? (cyc - acc_cyc) : 0;
            e_done = pend && (d == NIB + 1);
            e_busy = pend && (d >= 1) && (d <= NIB);
            check("ready", 32'(bus.ready), 32'(!pend));
            check("busy",  32'(bus.busy),  32'(e_busy));
            check("done",  32'(bus.done),  32'(e_done));
            if (e_done) begin
                e_res = exp_q.pop_front();
                check("sum",  32'(bus.sum),  32'(e_res[W-1:0]));
                check("cout", 32'(bus.cout), 32'(e_res[W]));
                check("ovf",  32'(bus.ovf),  32'(e_res[W+1]));
                last_res  = e_res;
                have_last = 1'b1;
                pend      = 1'b0;
            end else if (!pend && have_last) begin
                check("hold_sum",  32'(bus.sum),  32'(last_res[W-1:0]));
                check("hold_cout", 32'(bus.cout), 32'(last_res[W]));
                check("hold_ovf",  32'(bus.ovf),  32'(last_res[W+1]));
            end
        end
        rst_seen = rst;
        if (rst) begin
            pend = 1'b0;
            exp_q.delete();
            have_last = 1'b1;
            last_res  = '0;
        end else if (idle_now && bus.start) begin
            pend    = 1'b1;
            acc_cyc = cyc;
            exp_q.push_back(model(bus.a, bus.b, bus.cin));
        end
    end

    // ---------------- driver tasks (called #1 after a rising edge) ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles", n);
        end
    endtask

    // Issue one operation and wait for done. With hold set, start stays high with
    // all-ones operands while the operation runs.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input bit hold);
        int lat;
        wait_ready();
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.cin   = c;
        @(posedge clk); #1;
        bus.a   = W'($urandom());
        bus.b   = W'($urandom());
        bus.cin = 1'($urandom_range(0, 1));
        if (hold) begin
            bus.start = 1'b1;
            bus.a     = '1;
            bus.b     = '1;
            bus.cin   = 1'b1;
        end else begin
            bus.start = 1'b0;
        end
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles of accept", lat);
        end else begin
            check("latency", 32'(lat), NIB + 1);
        end
    endtask

    // Directed operation with hand-computed expectations; also pins the model.
    task automatic op_lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input bit hold, input logic [W-1:0] es, input logic ec,
                          input logic eo);
        logic [W+1:0] m;
        m = model(x, y, c);
        check("model_pin", 32'(m), 32'({eo, ec, es}));
        issue(x, y, c, hold);
        check("lit_sum",  32'(bus.sum),  32'(es));
        check("lit_cout", 32'(bus.cout), 32'(ec));
        check("lit_ovf",  32'(bus.ovf),  32'(eo));
    endtask

    // ---------------- main sequence ----------------
    int dones_after_abort;

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_ready", 32'(bus.ready), 1);
        check("init_busy",  32'(bus.busy),  0);
        check("init_done",  32'(bus.done),  0);
        check("init_sum",   32'(bus.sum),   0);

        op_lit(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        op_lit(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_lit(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        op_lit(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        op_lit(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ready_after_done", 32'(bus.ready), 1);

        // Abort an operation with reset two edges after accept.
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h4321;
        bus.cin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 32'(bus.ready), 1);
        check("abort_sum",   32'(bus.sum),   0);
        check("abort_cout",  32'(bus.cout),  0);
        dones_after_abort = 0;
        repeat (8) begin
            if (bus.done) dones_after_abort++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(dones_after_abort), 0);
        op_lit(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Overall time bound.
    initial begin
        #1000000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
